// File: rtl/xor_circular_decoder.sv
// Iterative circular-XOR decoder: strips mask(k) = {k, k, ...} from the encoded word,
// then rotates right one bit per cycle, k times, and presents the result with NZCV flags.
module xor_circular_decoder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned KW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [KW-1:0]    in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_n,
  output logic             out_z,
  output logic             out_c,
  output logic             out_v
);

  localparam int unsigned Reps = WIDTH / KW;

  typedef enum logic [1:0] {StIdle, StUnmask, StRotate, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q;
  logic [KW-1:0]    key_q;
  logic [KW-1:0]    cnt_q;
  logic [WIDTH-1:0] w_q;
  logic             c_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_n_q, out_z_q, out_c_q, out_v_q;
  logic [WIDTH-1:0] mask;

  assign mask      = {Reps{key_q}};
  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_n     = out_n_q;
  assign out_z     = out_z_q;
  assign out_c     = out_c_q;
  assign out_v     = out_v_q;

  // State register; reset aborts any word in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: UNMASK skips ROTATE for k == 0; ROTATE runs exactly k cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StUnmask;
      StUnmask: state_d = (cnt_q != '0) ? StRotate : StDone;
      StRotate: if (cnt_q == KW'(1)) state_d = StDone;
      StDone:   if (out_valid_q && out_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath: capture, unmask, rotate, then latch result and flags once in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      w_q         <= '0;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_n_q     <= 1'b0;
      out_z_q     <= 1'b0;
      out_c_q     <= 1'b0;
      out_v_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            y_q   <= in_data;
            key_q <= in_key;
            cnt_q <= in_key;
            // Cleared here so that k == 0 reports carry 0.
            c_q   <= 1'b0;
          end
        end
        StUnmask: begin
          w_q <= y_q ^ mask;
        end
        StRotate: begin
          w_q   <= {w_q[0], w_q[WIDTH-1:1]};
          c_q   <= w_q[0];
          cnt_q <= cnt_q - KW'(1);
        end
        StDone: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= w_q;
            out_n_q     <= w_q[WIDTH-1];
            out_z_q     <= (w_q == '0);
            out_c_q     <= c_q;
            out_v_q     <= w_q[WIDTH-1] ^ y_q[WIDTH-1];
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
